mod16_count_sequencer: RTL and testbench

//  Command-driven controller wrapped around a MOD-2^CNT_W (default MOD-16) up-counter.

---
 rtl/mod16_count_sequencer.sv | 151 +++++++++++++++
 tb/tb_mod16_count_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mod16_count_sequencer.sv
// mod16_count_sequencer
//   Command-driven controller around a MOD-2**CNT_W up-counter. A host hands it
//   one command at a time over a valid/ready handshake: run N full wrap passes,
//   count up to a target, load a value, or clear. Progress is reported through
//   busy, a per-wrap pulse, a wrap counter and completion/abort pulses.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low
//   cmd_valid    command present
//   cmd_ready    controller can accept a command (high only when idle)
//   cmd_op       00 PASSES, 01 COUNT_TO, 10 LOAD, 11 CLEAR
//   cmd_arg      PASSES: pass count N; COUNT_TO/LOAD: low CNT_W bits used
//   abort        cancel the running command
//   count        registered counter value
//   wrap         1-cycle pulse when count wraps max->0 during PASSES
//   passes_done  wraps completed in the current/last PASSES command
//   busy         a PASSES or COUNT_TO command is running
//   done         1-cycle pulse: command completed normally
//   aborted      1-cycle pulse: command cancelled by abort
//
// States
//   ST_IDLE     | waiting for a command; count/passes_done hold
//   ST_RUN_PASS | incrementing, counting wraps until passes_done reaches N
//   ST_RUN_TO   | incrementing until count reaches the target

module mod16_count_sequencer #(
  parameter int CNT_W  = 4,
  parameter int PASS_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [PASS_W-1:0] cmd_arg,
  input  logic              abort,
  output logic [CNT_W-1:0]  count,
  output logic              wrap,
  output logic [PASS_W-1:0] passes_done,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN_PASS = 2'd1;
  localparam logic [1:0] ST_RUN_TO   = 2'd2;

  localparam logic [1:0] OP_PASSES   = 2'b00;
  localparam logic [1:0] OP_COUNT_TO = 2'b01;
  localparam logic [1:0] OP_LOAD     = 2'b10;
  localparam logic [1:0] OP_CLEAR    = 2'b11;

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
  localparam logic [PASS_W-1:0] PASS_ONE = 1;

  logic [1:0]        state;
  logic [PASS_W-1:0] pass_target;
  logic [CNT_W-1:0]  to_target;
  logic [CNT_W-1:0]  count_inc;
  logic [PASS_W-1:0] passes_inc;
  logic [CNT_W-1:0]  arg_cnt;

  assign cmd_ready  = (state == ST_IDLE);
  assign busy       = ~cmd_ready;
  assign count_inc  = count + CNT_ONE;
  assign passes_inc = passes_done + PASS_ONE;
  assign arg_cnt    = cmd_arg[CNT_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      count       <= '0;
      passes_done <= '0;
      pass_target <= '0;
      to_target   <= '0;
      wrap        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      // Status outputs are single-cycle pulses unless re-asserted below.
      wrap    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_PASSES: begin
                count       <= '0;
                passes_done <= '0;
                pass_target <= cmd_arg;
                if (cmd_arg == '0) done  <= 1'b1;
                else               state <= ST_RUN_PASS;
              end
              OP_COUNT_TO: begin
                count     <= '0;
                to_target <= arg_cnt;
                if (arg_cnt == '0) done  <= 1'b1;
                else               state <= ST_RUN_TO;
              end
              OP_LOAD: begin
                count <= arg_cnt;
                done  <= 1'b1;
              end
              OP_CLEAR: begin
                count       <= '0;
                passes_done <= '0;
                done        <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_RUN_PASS: begin
          // Abort takes priority over a completing edge and freezes the counter.
          if (abort) begin
            aborted <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            count <= count_inc;
            if (count == CNT_MAX) begin
              wrap        <= 1'b1;
              passes_done <= passes_inc;
              if (passes_inc == pass_target) begin
                done  <= 1'b1;
                state <= ST_IDLE;
              end
            end
          end
        end
        ST_RUN_TO: begin
          if (abort) begin
            aborted <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            count <= count_inc;
            if (count_inc == to_target) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod16_count_sequencer.sv
module tb_mod16_count_sequencer;

  localparam int CNT_W  = 4;
  localparam int PASS_W = 8;
  localparam int MODV   = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = 2'b00;
  logic [PASS_W-1:0] cmd_arg = '0;
  logic              abort = 1'b0;
  logic [CNT_W-1:0]  count;
  logic              wrap;
  logic [PASS_W-1:0] passes_done;
  logic              busy;
  logic              done;
  logic              aborted;

  int n_checks = 0;
  int n_pass   = 0;
  int m_count  = 0;
  int m_passes = 0;

  mod16_count_sequencer #(.CNT_W(CNT_W), .PASS_W(PASS_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .abort(abort), .count(count),
    .wrap(wrap), .passes_done(passes_done), .busy(busy), .done(done),
    .aborted(aborted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " count"}, int'(count), m_count);
    check({tag, " passes"}, int'(passes_done), m_passes);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " ready"}, int'(cmd_ready), 1);
    check({tag, " done"}, int'(done), 0);
    check({tag, " wrap"}, int'(wrap), 0);
    check({tag, " aborted"}, int'(aborted), 0);
  endtask

  // Idle cycles with random abort/op/arg noise but no cmd_valid: nothing moves.
  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      cmd_valid = 1'b0;
      abort     = 1'($urandom % 2);
      cmd_op    = 2'($urandom % 4);
      cmd_arg   = PASS_W'($urandom);
      @(posedge clk);
      @(negedge clk);
      check_idle_outputs("idle");
    end
    abort = 1'b0;
  endtask

  // Runs one command from the current negedge. abort_at = index of the edge
  // (counted from the accept edge E0) at which abort is sampled; 0 = none.
  // The model is transaction-level: edge index -> expected outputs.
  task automatic do_cmd(input int op, input int arg, input int abort_at);
    int len, e_end, eff, ec, ep;
    bit ab;
    case (op)
      0:       len = arg * MODV;
      1:       len = arg % MODV;
      default: len = 0;
    endcase
    ab    = (abort_at >= 1) && (abort_at <= len);
    e_end = ab ? abort_at : len;
    check("accept ready", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_arg   = PASS_W'(arg);
    abort     = 1'($urandom % 2);
    for (int i = 0; i <= e_end; i++) begin
      @(posedge clk);
      @(negedge clk);
      eff = (ab && i == abort_at) ? i - 1 : i;
      case (op)
        0:       begin ec = eff % MODV; ep = eff / MODV; end
        1:       begin ec = eff;        ep = m_passes;   end
        2:       begin ec = arg % MODV; ep = m_passes;   end
        default: begin ec = 0;          ep = 0;          end
      endcase
      check("count", int'(count), ec);
      check("passes_done", int'(passes_done), ep);
      check("busy", int'(busy), (i < e_end) ? 1 : 0);
      check("cmd_ready", int'(cmd_ready), (i < e_end) ? 0 : 1);
      check("done", int'(done), (i == e_end && !ab) ? 1 : 0);
      check("aborted", int'(aborted), (i == e_end && ab) ? 1 : 0);
      check("wrap", int'(wrap),
            (op == 0 && i > 0 && (i % MODV) == 0 && !(ab && i == abort_at)) ? 1 : 0);
      if (i < e_end) begin
        // Commands presented while busy must be ignored.
        cmd_valid = 1'($urandom % 2);
        cmd_op    = 2'($urandom % 4);
        cmd_arg   = PASS_W'($urandom);
        abort     = (ab && i + 1 == abort_at) ? 1'b1 : 1'b0;
      end else begin
        cmd_valid = 1'b0;
        abort     = 1'b0;
      end
      m_count  = ec;
      m_passes = ep;
    end
  endtask

  initial begin
    int op, arg, len, ab_at;
    @(negedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("post reset");

    do_cmd(0, 2, 0);          // two full passes
    do_cmd(1, 5, 0);          // count to 5
    do_cmd(1, 0, 0);          // count to 0: immediate done
    do_cmd(2, 9, 0);          // load 9 ...
    do_cmd(0, 1, 0);          // ... then back-to-back single pass
    idle_cycles(2);
    do_cmd(0, 3, 21);         // abort at count=4 in pass 2
    idle_cycles(1);
    do_cmd(2, 8'hA7, 0);      // load uses low bits only
    do_cmd(3, 0, 0);          // clear
    do_cmd(0, 0, 0);          // zero passes
    do_cmd(1, 8'hF3, 2);      // count_to aborted early
    do_cmd(0, 1, 16);         // abort coinciding with completing edge

    // Async reset mid-pass at count=7.
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_arg = 8'd1; abort = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("pre-reset count", int'(count), 7);
    check("pre-reset busy", int'(busy), 1);
    #2 reset = 1'b0;
    #1;
    check("async count", int'(count), 0);
    check("async busy", int'(busy), 0);
    check("async ready", int'(cmd_ready), 1);
    check("async passes", int'(passes_done), 0);
    m_count = 0;
    m_passes = 0;
    @(negedge clk);
    reset = 1'b1;
    idle_cycles(1);

    for (int t = 0; t < 60; t++) begin
      op = int'($urandom % 4);
      if (op == 0) arg = ($urandom % 10 == 0) ? int'($urandom_range(0, 20))
                                             : int'($urandom_range(0, 3));
      else         arg = int'($urandom % 256);
      len = (op == 0) ? arg * MODV : (op == 1) ? arg % MODV : 0;
      ab_at = (len > 0 && $urandom % 3 == 0) ? int'($urandom_range(1, len)) : 0;
      do_cmd(op, arg, ab_at);
      if ($urandom % 2 == 0) idle_cycles(int'($urandom_range(1, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
